// File: rtl/seq_det_sched.sv
// Round-robin shared "1010" Mealy detector over NCH serial channels with per-channel contexts.
// Optional per-channel saturating match counters are enabled by defining MATCH_COUNT_EN.
module seq_det_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           ch_din,
  output logic [NCH-1:0]           ch_ready,
  input  logic                     flush,
  output logic                     match_valid,
`ifdef MATCH_COUNT_EN
  output logic [$clog2(NCH)-1:0]   match_ch,
  input  logic [$clog2(NCH)-1:0]   cnt_sel,
  input  logic                     cnt_clr,
  output logic [CW-1:0]            cnt_value
`else
  output logic [$clog2(NCH)-1:0]   match_ch
`endif
);

  localparam int PW = $clog2(NCH);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t          ctx_reg  [NCH];
  state_t          ctx_next [NCH];
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic            match_valid_reg;
  logic [PW-1:0]   match_ch_reg, match_ch_next;
  logic            hit_next;
  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW:0]     scan_idx;
  logic            grant_bit;

  // Scan from ptr with wrap; the extra index bit keeps the sum from aliasing before the wrap.
  always_comb begin
    ch_ready    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = {1'b0, ptr_reg} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NCH))
        scan_idx = scan_idx - (PW+1)'(NCH);
      if (!grant_found && ch_valid[scan_idx[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PW-1:0];
      end
    end
    if (flush)
      grant_found = 1'b0;
    if (grant_found)
      ch_ready[grant_idx] = 1'b1;
  end

  assign grant_bit = ch_din[grant_idx];

  always_comb begin
    for (int i = 0; i < NCH; i++)
      ctx_next[i] = ctx_reg[i];
    ptr_next      = ptr_reg;
    hit_next      = 1'b0;
    match_ch_next = match_ch_reg;
    if (flush) begin
      for (int i = 0; i < NCH; i++)
        ctx_next[i] = S0;
    end else if (grant_found) begin
      ptr_next = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
      case (ctx_reg[grant_idx])
        S0: ctx_next[grant_idx] = grant_bit ? S1 : S0;
        S1: ctx_next[grant_idx] = grant_bit ? S1 : S2;
        S2: ctx_next[grant_idx] = grant_bit ? S3 : S0;
        S3: begin
          // Non-overlapping: a completed match restarts the channel from idle.
          ctx_next[grant_idx] = grant_bit ? S1 : S0;
          hit_next            = !grant_bit;
        end
      endcase
      if (hit_next)
        match_ch_next = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++)
        ctx_reg[i] <= S0;
      ptr_reg         <= '0;
      match_valid_reg <= 1'b0;
      match_ch_reg    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        ctx_reg[i] <= ctx_next[i];
      ptr_reg         <= ptr_next;
      match_valid_reg <= hit_next;
      match_ch_reg    <= match_ch_next;
    end
  end

  assign match_valid = match_valid_reg;
  assign match_ch    = match_ch_reg;

`ifdef MATCH_COUNT_EN
  logic [CW-1:0] cnt_reg  [NCH];
  logic [CW-1:0] cnt_next [NCH];

  // Clear wins over a same-cycle increment on the selected channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_next[i] = cnt_reg[i];
      if (hit_next && grant_idx == PW'(i) && cnt_reg[i] != '1)
        cnt_next[i] = cnt_reg[i] + CW'(1);
      if (cnt_clr && cnt_sel == PW'(i))
        cnt_next[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++)
        cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        cnt_reg[i] <= cnt_next[i];
    end
  end

  assign cnt_value = ({1'b0, cnt_sel} < (PW+1)'(NCH)) ? cnt_reg[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: vector table plus a reference model feeding a match queue.
module tb_seq_det_sched;
  localparam int NCH = 4;
`ifdef MATCH_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_valid, ch_din, ch_ready;
  logic           flush;
  logic           match_valid;
  logic [1:0]     match_ch;
`ifdef MATCH_COUNT_EN
  logic [1:0]     cnt_sel;
  logic           cnt_clr;
  logic [CW-1:0]  cnt_value;
`endif

  seq_det_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk),
    .reset(reset),
    .ch_valid(ch_valid),
    .ch_din(ch_din),
    .ch_ready(ch_ready),
    .flush(flush),
    .match_valid(match_valid),
    .match_ch(match_ch)
`ifdef MATCH_COUNT_EN
    , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_value(cnt_value)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q[$];
  logic [1:0] m_state [NCH];
  int m_ptr;
  int m_cnt [NCH];

  typedef struct {
    logic [3:0] v;
    logic [3:0] d;
    logic       f;
    logic [3:0] er;
    logic       em;
    logic [1:0] ech;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_state[i] = 2'd0;
      m_cnt[i]   = 0;
    end
    m_ptr = 0;
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_valid = '0; ch_din = '0; flush = 1'b0;
`ifdef MATCH_COUNT_EN
    cnt_clr = 1'b0; cnt_sel = 2'd1;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk("reset_match_valid", match_valid, 0);
    chk("reset_match_ch", match_ch, 0);
    chk("reset_ch_ready", ch_ready, 0);
`ifdef MATCH_COUNT_EN
    chk("reset_cnt_value", cnt_value, 0);
`endif
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: drive, check grant against the model, advance model, check the registered match.
  task automatic cycle(input logic [3:0] v, input logic [3:0] d, input logic f, input logic clr,
                       output logic [3:0] rdy, output logic mv, output logic [1:0] mch, output int g);
    logic [3:0] mg;
    logic em;
    ch_valid = v; ch_din = d; flush = f;
`ifdef MATCH_COUNT_EN
    cnt_clr = clr;
`endif
    mg = '0; g = -1;
    if (!f) begin
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (m_ptr + k) % NCH;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) mg[g] = 1'b1;
    #1;
    rdy = ch_ready;
    chk("ch_ready", ch_ready, mg);
    @(posedge clk);
    em = 1'b0;
    if (f) begin
      for (int i = 0; i < NCH; i++) m_state[i] = 2'd0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NCH;
      case (m_state[g])
        2'd0: m_state[g] = d[g] ? 2'd1 : 2'd0;
        2'd1: m_state[g] = d[g] ? 2'd1 : 2'd2;
        2'd2: m_state[g] = d[g] ? 2'd3 : 2'd0;
        default: begin
          if (!d[g]) begin
            em = 1'b1;
            q.push_back(g);
          end
          m_state[g] = d[g] ? 2'd1 : 2'd0;
        end
      endcase
    end
`ifdef MATCH_COUNT_EN
    if (em && m_cnt[g] < 3) m_cnt[g]++;
    if (clr) m_cnt[cnt_sel] = 0;
`endif
    #1;
    mv = match_valid; mch = match_ch;
    $display("t=%0t valid=%b din=%b flush=%b ready=%b match_valid=%b match_ch=%0d",
             $time, v, d, f, rdy, mv, mch);
    chk("match_valid", match_valid, em);
    if (match_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL match_unexpected: got match on ch %0d required none", match_ch);
      end else begin
        chk("match_ch", match_ch, q.pop_front());
      end
    end
`ifdef MATCH_COUNT_EN
    chk("cnt_value", cnt_value, m_cnt[cnt_sel]);
`endif
  endtask

  function automatic logic pat_bit(input int p);
    return (p == 0 || p == 2);
  endfunction

  initial begin
    logic [3:0] rdy;
    logic mv;
    logic [1:0] mch;
    int g;
    int pos [NCH];
    int mcount;
    logic b;

    for (int i = 0; i < 8; i++) begin
      b = pat_bit(i % 4);
      tbl[i] = '{v: 4'b0001, d: {3'b0, b}, f: 1'b0, er: 4'b0001, em: (i == 3 || i == 7), ech: 2'd0};
    end
    for (int i = 0; i < 6; i++) begin
      b = pat_bit(i % 4);
      tbl[8+i] = '{v: 4'b0010, d: {2'b0, b, 1'b0}, f: 1'b0, er: 4'b0010, em: (i == 3), ech: 2'd1};
    end

    do_reset();

    // Channel 0 twice "1010", then channel 1 overlap candidate "101010".
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].f, 1'b0, rdy, mv, mch, g);
      chk("tbl_ready", rdy, tbl[i].er);
      chk("tbl_match_valid", mv, tbl[i].em);
      if (tbl[i].em) chk("tbl_match_ch", mch, tbl[i].ech);
    end

    // All channels valid: rotating grants, four matches in consecutive cycles.
    do_reset();
    for (int i = 0; i < NCH; i++) pos[i] = 0;
    mcount = 0;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] v;
      logic [3:0] d;
      for (int i = 0; i < NCH; i++) begin
        v[i] = (pos[i] < 4);
        d[i] = (pos[i] < 4) ? pat_bit(pos[i]) : 1'b0;
      end
      cycle(v, d, 1'b0, 1'b0, rdy, mv, mch, g);
      if (g >= 0) pos[g]++;
      chk("rr_ready", rdy, 4'b0001 << (c % 4));
      chk("rr_match_valid", mv, c >= 12);
      if (c >= 12) chk("rr_match_ch", mch, c - 12);
      if (mv) mcount++;
    end
    chk("rr_match_count", mcount, 4);

    // Channel 2: "101", flush, "0" (no match), then "1010" (match).
    begin
      logic [8:0] bits;
      logic [8:0] fl;
      bits = 9'b010100101;
      fl   = 9'b000001000;
      for (int i = 0; i < 9; i++) begin
        cycle(4'b0100, {1'b0, bits[i], 2'b0}, fl[i], 1'b0, rdy, mv, mch, g);
        if (fl[i]) chk("flush_ready", rdy, 0);
        chk("flush_match_valid", mv, i == 8);
        if (i == 8) chk("flush_match_ch", mch, 2);
      end
    end

    // Channel 3 "101", channel 0 "1010", then async reset while match_valid is high.
    for (int i = 0; i < 3; i++)
      cycle(4'b1000, {pat_bit(i), 3'b0}, 1'b0, 1'b0, rdy, mv, mch, g);
    for (int i = 0; i < 4; i++)
      cycle(4'b0001, {3'b0, pat_bit(i)}, 1'b0, 1'b0, rdy, mv, mch, g);
    chk("pre_reset_match_valid", mv, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_match_valid", match_valid, 0);
    chk("async_reset_match_ch", match_ch, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cycle(4'b1000, 4'b0000, 1'b0, 1'b0, rdy, mv, mch, g);
    chk("post_reset_no_match", mv, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1000, {pat_bit(i), 3'b0}, 1'b0, 1'b0, rdy, mv, mch, g);
      chk("post_reset_match_valid", mv, i == 3);
      if (i == 3) chk("post_reset_match_ch", mch, 3);
    end

`ifdef MATCH_COUNT_EN
    // Counter saturation at 3, then clear coincident with a sixth match.
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(4'b0010, {2'b0, pat_bit(i % 4), 1'b0}, 1'b0, 1'b0, rdy, mv, mch, g);
    chk("cnt_saturated", cnt_value, 3);
    for (int i = 0; i < 4; i++)
      cycle(4'b0010, {2'b0, pat_bit(i), 1'b0}, 1'b0, i == 3, rdy, mv, mch, g);
    chk("cnt_clr_with_match", cnt_value, 0);
    chk("cnt_clr_match_seen", mv, 1);
    cnt_clr = 1'b0;
`endif

    ch_valid = '0;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
